apple2_ps2_keyboard: RTL
========================

Name: apple2_ps2_keyboard

Overview:
Replaces the one-button keyboard stub with a real PS/2 keyboard front end feeding the CPU read mux at $C000/$C010. The block has four stages: it deserialises PS/2 frames, decodes set-2 scan codes (make/break, E0 extended, shift/ctrl state), translates them to Apple II 7-bit uppercase ASCII, and holds the result in the Apple II keyboard latch with its bit-7 strobe. It sits in the pixel-clock domain beside the RAM/ROM decode and drives kb_data into cpu_data_in.

Parameters:
FILT_CYCLES, 8, clk cycles ps2_clk must be stable before an edge is accepted
TIMEOUT_CYCLES, 50000, idle clk cycles mid-frame before the frame is abandoned (~2 ms at 25.175 MHz)

Ports:
clk  input  1  system clock (pixel clock domain)
rst  input  1  synchronous reset, active-high
ps2_clk  input  1  raw PS/2 clock from pad (asynchronous)
ps2_data  input  1  raw PS/2 data from pad (asynchronous)
addr  input  16  CPU address bus
access  input  1  CPU bus cycle valid this clk (read or write)
kb_data  output  8  {strobe, key[6:0]}, valid whenever addr is in $C000-$C01F
key_strobe  output  1  latch strobe bit (for debug/LED)
frame_err  output  1  one-clk pulse on parity, start or stop error, or on timeout

Behaviour:
- Reset: rx FSM to IDLE, shift/ctrl/break/ext flags to 0, key to 7'h00, strobe to 0. kb_data = 8'h00, key_strobe = 0, frame_err = 0.
- Input conditioning: 2-flop synchroniser on both lines. ps2_clk is filtered: the filtered level changes only after FILT_CYCLES consecutive equal samples. A falling edge of the filtered clock samples synchronised data.
- Rx FSM, one bit per falling edge, data LSB first:
  - IDLE: if the sampled bit is 0, go to DATA with cnt = 0; otherwise stay in IDLE and pulse frame_err.
  - DATA: after 8 bits, go to PARITY.
  - PARITY: check for odd parity, then go to STOP.
  - STOP: the bit must be 1. With good parity, pulse byte_valid for one clk. Otherwise discard the byte and pulse frame_err. Return to IDLE.
  - Timeout: in any state except IDLE, if no edge arrives for TIMEOUT_CYCLES, go to IDLE and pulse frame_err.
- Decoder, on byte_valid:
  - F0 sets break. E0 sets ext.
  - Any other byte is a keycode: process it, then clear break and ext.
  - 12/59 set shift to !break. 14 sets ctrl to !break (E0 14 also counts).
  - All other break codes are ignored. E1 sequences are ignored (decoder holds ignore for 7 bytes).
- Translation (make codes only, 7-bit, letters always uppercase):
  - Letters A-Z give 0x41-0x5A. With ctrl they give 0x01-0x1A.
  - Digits 0-9 (45,16,1E,26,25,2E,36,3D,3E,46) give 0x30-0x39. With shift they give US symbols ")!@#$%^&*(".
  - Space 29 gives 0x20. Enter 5A gives 0x0D. Backspace 66 gives 0x08. Esc 76 gives 0x1B.
  - E0 6B (left) gives 0x08. E0 74 (right) gives 0x15.
  - Punctuation: 41 gives , / <. 49 gives . / >. 4A gives / / ?. 4C gives ; / :. 52 gives ' / ". 4E gives - / _. 55 gives = / +.
  - Unmapped codes produce no key.
- Latch:
  - A translated key loads key[6:0] and sets strobe to 1 in the clk after its byte_valid. A new key overwrites an unread key.
  - access with addr[15:4] = 12'hC01 clears strobe, reads and writes alike. kb_data in that cycle still shows the pre-clear value.
  - If a new key and a clear land in the same clk, the new key wins (strobe = 1).
  - kb_data = {strobe, key} combinationally from the registers, for addr $C000-$C01F. For other addresses it outputs 8'h00.
- Reset mid-frame discards the partial byte and all modifier state.

Optional Feature:
TYPEAHEAD_FIFO_EN
- Defined: a 4-entry FIFO sits between the translator and the latch.
  - When strobe is 0 and the FIFO is not empty, the head entry moves into the latch (strobe = 1) the next clk.
  - A push when the FIFO is full drops the new key and pulses frame_err.
  - A clear and a pop can occur in the same clk: the clear wins for that clk, and the pop follows on the next clk.
- Undefined: no FIFO. Keys go straight to the latch and overwrite it.

Test Plan:
- Frame 1C, then F0 1C -> kb_data at $C000 = 0xC1. After access at $C010: $C000 reads 0x41 and key_strobe = 0.
- 12, 16, F0 16, F0 12 -> 0xA1 ('!'). Then 16 -> 0xB1 ('1'), showing shift was released.
- 14, 23 (ctrl-D) -> 0x84. E0 74 -> 0x95. 5A -> 0x8D.
- Frame 1C with bad parity -> frame_err pulses once and kb_data is unchanged. A frame stalled after 4 bits for TIMEOUT_CYCLES+1 clks -> frame_err, FSM in IDLE, and the next good frame decodes correctly.
- A key completing in the same clk as an access at $C010 -> strobe = 1 afterwards. An access at $C005 (mirror) reads the same value as $C000.
- TYPEAHEAD_FIFO_EN: press A, B, C, D, E without reading -> reads return 0xC1, 0xC2, 0xC3, 0xC4, each followed by a clear. E is dropped with frame_err, and a final read returns 0x44.

Source files
------------

// File: rtl/apple2_ps2_keyboard_if.sv
// CPU-side bus for the Apple II keyboard latch: address/access from the CPU,
// kb_data back into the read mux for $C000-$C01F.
interface apple2_ps2_keyboard_if;
   logic [15:0] addr;
   logic        access;
   logic [7:0]  kb_data;

   modport master (output addr, output access, input kb_data);
   modport slave  (input addr, input access, output kb_data);
endinterface

// File: rtl/apple2_ps2_keyboard.sv
// PS/2 set-2 keyboard front end feeding the Apple II $C000/$C010 keyboard latch.
// Optional 4-deep typeahead between translator and latch: define TYPEAHEAD_FIFO_EN.
module apple2_ps2_keyboard #(
   parameter int unsigned FILT_CYCLES    = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ps2_clk,
   input  logic                        ps2_data,
   apple2_ps2_keyboard_if.slave        bus,
   output logic                        key_strobe,
   output logic                        frame_err
);

   localparam int unsigned FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

   logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
   logic          clk_filt_q, clk_filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall, rx_bit, rx_err;

   rx_state_e     rx_state_q, rx_state_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          byte_valid_q, byte_valid_d;
   logic [7:0]    rx_byte_q, rx_byte_d;

   logic          brk_q, brk_d, ext_q, ext_d, shift_q, shift_d, ctrl_q, ctrl_d;
   logic [2:0]    ign_q, ign_d;
   logic          key_valid;
   logic [6:0]    key_code;

   logic [6:0]    key_q, key_d;
   logic          strobe_q, strobe_d;
   logic          frame_err_q, frame_err_d;
   logic          clear, drop;
   logic          unused_addr_lo;

   assign unused_addr_lo = ^bus.addr[3:0];

   // {hit, ascii[6:0]} for a make code; letters are always uppercase
   function automatic logic [7:0] xlate(input logic [7:0] code, input logic ext,
                                        input logic shift, input logic ctrl);
      logic       hit;
      logic [6:0] ch;
      hit = 1'b1;
      ch  = '0;
      if (ext) begin
         case (code)
            8'h6B:   ch = 7'h08;
            8'h74:   ch = 7'h15;
            default: hit = 1'b0;
         endcase
      end else begin
         case (code)
            8'h1C: ch = 7'h41;  8'h32: ch = 7'h42;  8'h21: ch = 7'h43;  8'h23: ch = 7'h44;
            8'h24: ch = 7'h45;  8'h2B: ch = 7'h46;  8'h34: ch = 7'h47;  8'h33: ch = 7'h48;
            8'h43: ch = 7'h49;  8'h3B: ch = 7'h4A;  8'h42: ch = 7'h4B;  8'h4B: ch = 7'h4C;
            8'h3A: ch = 7'h4D;  8'h31: ch = 7'h4E;  8'h44: ch = 7'h4F;  8'h4D: ch = 7'h50;
            8'h15: ch = 7'h51;  8'h2D: ch = 7'h52;  8'h1B: ch = 7'h53;  8'h2C: ch = 7'h54;
            8'h3C: ch = 7'h55;  8'h2A: ch = 7'h56;  8'h1D: ch = 7'h57;  8'h22: ch = 7'h58;
            8'h35: ch = 7'h59;  8'h1A: ch = 7'h5A;
            8'h45: ch = shift ? 7'h29 : 7'h30;
            8'h16: ch = shift ? 7'h21 : 7'h31;
            8'h1E: ch = shift ? 7'h40 : 7'h32;
            8'h26: ch = shift ? 7'h23 : 7'h33;
            8'h25: ch = shift ? 7'h24 : 7'h34;
            8'h2E: ch = shift ? 7'h25 : 7'h35;
            8'h36: ch = shift ? 7'h5E : 7'h36;
            8'h3D: ch = shift ? 7'h26 : 7'h37;
            8'h3E: ch = shift ? 7'h2A : 7'h38;
            8'h46: ch = shift ? 7'h28 : 7'h39;
            8'h41: ch = shift ? 7'h3C : 7'h2C;
            8'h49: ch = shift ? 7'h3E : 7'h2E;
            8'h4A: ch = shift ? 7'h3F : 7'h2F;
            8'h4C: ch = shift ? 7'h3A : 7'h3B;
            8'h52: ch = shift ? 7'h22 : 7'h27;
            8'h4E: ch = shift ? 7'h5F : 7'h2D;
            8'h55: ch = shift ? 7'h2B : 7'h3D;
            8'h29: ch = 7'h20;
            8'h5A: ch = 7'h0D;
            8'h66: ch = 7'h08;
            8'h76: ch = 7'h1B;
            default: hit = 1'b0;
         endcase
         if (ctrl && ch >= 7'h41 && ch <= 7'h5A) ch = ch - 7'h40;
      end
      return {hit, ch};
   endfunction

   // Input conditioning: filtered clock flips only after FILT_CYCLES differing samples
   always_comb begin
      clk_sync_d = {clk_sync_q[0], ps2_clk};
      dat_sync_d = {dat_sync_q[0], ps2_data};
      clk_filt_d = clk_filt_q;
      filt_cnt_d = '0;
      fall       = 1'b0;
      if (clk_sync_q[1] != clk_filt_q) begin
         if (filt_cnt_q == FW'(FILT_CYCLES - 1)) begin
            clk_filt_d = clk_sync_q[1];
            fall       = clk_filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign rx_bit = dat_sync_q[1];

   always_comb begin
      rx_state_d   = rx_state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      par_ok_d     = par_ok_q;
      byte_valid_d = 1'b0;
      rx_byte_d    = rx_byte_q;
      rx_err       = 1'b0;
      tmo_d        = (rx_state_q == RX_IDLE || fall) ? '0 : tmo_q + 1'b1;
      if (fall) begin
         case (rx_state_q)
            RX_IDLE: begin
               if (!rx_bit) begin
                  rx_state_d = RX_DATA;
                  bit_cnt_d  = '0;
               end else begin
                  rx_err = 1'b1;
               end
            end
            RX_DATA: begin
               shreg_d   = {rx_bit, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
            end
            RX_PARITY: begin
               par_ok_d   = ^{shreg_q, rx_bit};
               rx_state_d = RX_STOP;
            end
            default: begin
               if (rx_bit && par_ok_q) begin
                  byte_valid_d = 1'b1;
                  rx_byte_d    = shreg_q;
               end else begin
                  rx_err = 1'b1;
               end
               rx_state_d = RX_IDLE;
            end
         endcase
      end else if (rx_state_q != RX_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         rx_state_d = RX_IDLE;
         rx_err     = 1'b1;
      end
   end

   // Scan-code decoder; E1 (Pause) sequences are swallowed for the next 7 bytes
   always_comb begin
      brk_d     = brk_q;
      ext_d     = ext_q;
      shift_d   = shift_q;
      ctrl_d    = ctrl_q;
      ign_d     = ign_q;
      key_valid = 1'b0;
      key_code  = '0;
      if (byte_valid_q) begin
         if (ign_q != 3'd0) begin
            ign_d = ign_q - 1'b1;
         end else if (rx_byte_q == 8'hE1) begin
            ign_d = 3'd7;
         end else if (rx_byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (rx_byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            case (rx_byte_q)
               8'h12, 8'h59: shift_d = !brk_q;
               8'h14:        ctrl_d  = !brk_q;
               default: if (!brk_q) {key_valid, key_code} = xlate(rx_byte_q, ext_q, shift_q, ctrl_q);
            endcase
         end
      end
   end

   assign clear       = bus.access && (bus.addr[15:4] == 12'hC01);
   assign bus.kb_data = (bus.addr[15:5] == 11'h600) ? {strobe_q, key_q} : 8'h00;
   assign key_strobe  = strobe_q;
   assign frame_err   = frame_err_q;

`ifdef TYPEAHEAD_FIFO_EN
   logic [6:0] fifo_q [4];
   logic [6:0] fifo_d [4];
   logic [1:0] wr_q, wr_d, rd_q, rd_d;
   logic [2:0] cnt_q, cnt_d, pend;
   logic       push, pop;

   // An unread latched key counts against capacity: at most four keys pending in total
   always_comb begin
      fifo_d   = fifo_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      key_d    = key_q;
      strobe_d = strobe_q;
      pend     = cnt_q + {2'b00, strobe_q};
      pop      = !strobe_q && (cnt_q != 3'd0) && !clear;
      push     = key_valid && (pend < 3'd4);
      drop     = key_valid && !push;
      if (push) begin
         fifo_d[wr_q] = key_code;
         wr_d         = wr_q + 1'b1;
      end
      if (clear) strobe_d = 1'b0;
      if (pop) begin
         key_d    = fifo_q[rd_q];
         strobe_d = 1'b1;
         rd_d     = rd_q + 1'b1;
      end
      cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q <= '{default: '0};
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
      end else begin
         fifo_q <= fifo_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
      end
   end
`else
   always_comb begin
      key_d    = key_q;
      strobe_d = strobe_q;
      drop     = 1'b0;
      if (key_valid) begin
         key_d    = key_code;
         strobe_d = 1'b1;
      end else if (clear) begin
         strobe_d = 1'b0;
      end
   end
`endif

   assign frame_err_d = rx_err | drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q   <= 2'b11;
         dat_sync_q   <= 2'b11;
         clk_filt_q   <= 1'b1;
         filt_cnt_q   <= '0;
         rx_state_q   <= RX_IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         par_ok_q     <= 1'b0;
         tmo_q        <= '0;
         byte_valid_q <= 1'b0;
         rx_byte_q    <= '0;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         shift_q      <= 1'b0;
         ctrl_q       <= 1'b0;
         ign_q        <= '0;
         key_q        <= '0;
         strobe_q     <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         dat_sync_q   <= dat_sync_d;
         clk_filt_q   <= clk_filt_d;
         filt_cnt_q   <= filt_cnt_d;
         rx_state_q   <= rx_state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         par_ok_q     <= par_ok_d;
         tmo_q        <= tmo_d;
         byte_valid_q <= byte_valid_d;
         rx_byte_q    <= rx_byte_d;
         brk_q        <= brk_d;
         ext_q        <= ext_d;
         shift_q      <= shift_d;
         ctrl_q       <= ctrl_d;
         ign_q        <= ign_d;
         key_q        <= key_d;
         strobe_q     <= strobe_d;
         frame_err_q  <= frame_err_d;
      end
   end

endmodule
